traffic_request_latch: RTL
==========================

Name: traffic_request_latch

Overview:
Upstream stage of traffic_light_controller that conditions the NS, EW and pedestrian sensor inputs.
- Synchronizes the raw switch-level sensors.
- Latches each request until the controller grants service.
- Ages each pending request in tick units, flags starvation and names the oldest pending direction.
- Outputs feed the controller's car_ns/car_ew/ped inputs directly; next_dir/starve_* are available for a priority-aware controller revision.

Parameters:
WAIT_WIDTH, 4, width of each per-direction wait counter.
MAX_WAIT, 10, wait count at or above which a pending request is flagged starved; must satisfy 1 <= MAX_WAIT <= 2^WAIT_WIDTH-1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-high reset.
tick  input  1  one-cycle aging enable (1 Hz strobe in system; tie 1 when clk is clk_1hz).
sensor_ns  input  1  raw NS car sensor, asynchronous level.
sensor_ew  input  1  raw EW car sensor, asynchronous level.
sensor_ped  input  1  raw pedestrian button, asynchronous level.
grant_ns  input  1  controller serving NS (NS green), level.
grant_ew  input  1  controller serving EW (EW green), level.
grant_ped  input  1  controller serving pedestrians (walk), level.
req_ns, req_ew, req_ped  output  1 each  latched pending requests.
any_req  output  1  OR of the three req outputs, combinational.
wait_ns, wait_ew, wait_ped  output  WAIT_WIDTH each  ticks each request has been pending.
starve_ns, starve_ew, starve_ped  output  1 each  req_x AND wait_x >= MAX_WAIT, combinational from registers.
next_dir  output  2  oldest pending direction: 00 none, 01 NS, 10 EW, 11 PED.
starve_pulse  output  1  see Optional Feature.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All registers are sampled on the rising edge of clk.
- Reset values: synchronizers, req_*, wait_* and next_dir all clear to 0. starve_pulse is 0. Reset overrides every other input, including when applied mid-wait or while a grant is active.
- Synchronizer: 2 flops per sensor. A sensor high before edge 1 produces req_x high after edge 3 (3-cycle latency).
- Request register, per direction, evaluated in priority order:
  - grant_x=1 -> req_x=0 (clear wins over set in the same cycle).
  - Otherwise synced sensor_x=1 -> req_x=1.
  - Otherwise req_x holds.
- Sticky requests: a sensor pulse lasting 3 or more cycles leaves req_x set after the sensor drops, until the next grant. If the sensor is still high when the grant falls, req_x re-asserts on the next edge.
- Wait counter, per direction:
  - req_x=0 or grant_x=1 -> wait_x=0.
  - Otherwise tick=1 -> wait_x+1, saturating at 2^WAIT_WIDTH-1 (no wrap).
  - The counter first increments on the first tick after req_x is seen high.
- starve_x: combinational from req_x and wait_x; drops in the cycle req_x clears.
- next_dir: registered, 1-cycle latency from req_*/wait_*.
  - Selects the pending direction with the largest wait_x.
  - Ties break PED > NS > EW.
  - Is 00 when no request is pending.
- Grants: any combination, including all three at once, is accepted without error; each clears only its own direction.
- tick: no behavioural dependence on tick rate; tick held high ages every cycle.

Optional Feature:
Macro STARVE_PULSE_EN.
- Defined: starve_pulse is a registered one-cycle pulse on the edge after any starve_x rises 0->1. Simultaneous rises produce a single pulse. A flag that stays high does not pulse again until it falls and rises.
- Undefined: starve_pulse is tied 0 and no edge-detect registers are built.

Test Plan:
- Reset then sensor_ns=1 for 1 cycle -> req_ns stays 0 (pulse too short to reach the request register after sync). sensor_ns=1 held 3 cycles -> req_ns=1 after edge 3, remains 1 after sensor drops; next_dir=01 one cycle later.
- req_ew pending, tick every cycle, MAX_WAIT=10 -> wait_ew counts 1..10. starve_ew=1 when wait_ew=10. wait_ew saturates at 15, never wraps to 0. With STARVE_PULSE_EN, starve_pulse is high exactly one cycle.
- req_ped pending with wait 3; sensor_ped held, grant_ped=1 -> req_ped=0 and wait_ped=0 next edge, stays 0 while grant held. grant_ped drops with sensor still high -> req_ped=1 on the following edge.
- NS and PED raised in the same cycle, equal waits -> next_dir=11 (PED tie-break). NS raised 2 ticks earlier -> next_dir=01.
- Mid-operation rst=1 with all three requests pending, waits 5/7/9 and grant_ew=1 -> all req/wait/next_dir=0 after one edge; starve_pulse=0.
- All three grants asserted while all requests pending -> all req_* clear on the same edge; any_req=0; next_dir=00 one edge later.

Source files
------------

// File: rtl/traffic_request_latch.sv
// Sensor conditioning ahead of traffic_light_controller: sync, latch, age, pick oldest.
// Optional STARVE_PULSE_EN adds a one-cycle pulse when any direction becomes starved.
module traffic_request_latch #(
    parameter int WAIT_WIDTH = 4,
    parameter int MAX_WAIT   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  sensor_ns,
    input  logic                  sensor_ew,
    input  logic                  sensor_ped,
    input  logic                  grant_ns,
    input  logic                  grant_ew,
    input  logic                  grant_ped,
    output logic                  req_ns,
    output logic                  req_ew,
    output logic                  req_ped,
    output logic                  any_req,
    output logic [WAIT_WIDTH-1:0] wait_ns,
    output logic [WAIT_WIDTH-1:0] wait_ew,
    output logic [WAIT_WIDTH-1:0] wait_ped,
    output logic                  starve_ns,
    output logic                  starve_ew,
    output logic                  starve_ped,
    output logic [1:0]            next_dir,
    output logic                  starve_pulse
);

    localparam logic [WAIT_WIDTH-1:0] W_SAT = '1;
    localparam logic [WAIT_WIDTH-1:0] W_THR = WAIT_WIDTH'(MAX_WAIT);

    // Index 0 = NS, 1 = EW, 2 = PED throughout.
    logic [2:0]            w_sensor;
    logic [2:0]            w_grant;
    logic [2:0]            w_starve;
    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_req;
    logic [WAIT_WIDTH-1:0] r_wait [3];
    logic [1:0]            r_next_dir;
    logic [1:0]            w_next_dir;

    assign w_sensor = {sensor_ped, sensor_ew, sensor_ns};
    assign w_grant  = {grant_ped, grant_ew, grant_ns};

    // A request needs two consecutive synced samples, so one-cycle glitches are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_req   <= '0;
        end else begin
            r_sync1 <= w_sensor;
            r_sync2 <= r_sync1;
            r_req   <= ~w_grant & (r_req | (r_sync1 & r_sync2));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || !r_req[i] || w_grant[i])
                r_wait[i] <= '0;
            else if (tick && r_wait[i] != W_SAT)
                r_wait[i] <= r_wait[i] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            w_starve[i] = r_req[i] && (r_wait[i] >= W_THR);
    end

    // Oldest pending wins; equal ages resolve PED, then NS, then EW.
    always_comb begin
        w_next_dir = 2'b00;
        if (r_req[2]
            && (!r_req[0] || r_wait[2] >= r_wait[0])
            && (!r_req[1] || r_wait[2] >= r_wait[1]))
            w_next_dir = 2'b11;
        else if (r_req[0] && (!r_req[1] || r_wait[0] >= r_wait[1]))
            w_next_dir = 2'b01;
        else if (r_req[1])
            w_next_dir = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_next_dir <= 2'b00;
        else
            r_next_dir <= w_next_dir;
    end

`ifdef STARVE_PULSE_EN
    logic [2:0] r_starve_d;
    logic       r_starve_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_d     <= '0;
            r_starve_pulse <= 1'b0;
        end else begin
            r_starve_d     <= w_starve;
            r_starve_pulse <= |(w_starve & ~r_starve_d);
        end
    end

    assign starve_pulse = r_starve_pulse;
`else
    assign starve_pulse = 1'b0;
`endif

    assign req_ns     = r_req[0];
    assign req_ew     = r_req[1];
    assign req_ped    = r_req[2];
    assign any_req    = |r_req;
    assign wait_ns    = r_wait[0];
    assign wait_ew    = r_wait[1];
    assign wait_ped   = r_wait[2];
    assign starve_ns  = w_starve[0];
    assign starve_ew  = w_starve[1];
    assign starve_ped = w_starve[2];
    assign next_dir   = r_next_dir;

endmodule
